sram_req_arbiter: RTL and testbench
===================================

Name: sram_req_arbiter

Overview:
- Shares one sram-like memory port between two sram-like requesters: instruction fetch (inst_sram_*) and load/store (data_sram_*).
- Sits between the pipeline stages and the AXI bridge.
- Fixed priority, data over inst; a granted request stays locked until accepted.
- Returns data_ok/rdata to the owning requester in order, via an ID FIFO of outstanding requests.

Parameters:
- OUTST_DEPTH, 4: max accepted-but-unanswered requests; power of two, 2..16.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

Ports:
- clk  in  1  clock; all logic on posedge.
- resetn  in  1  synchronous active-low reset.
- inst_sram_req  in  1  inst request.
- inst_sram_wr  in  1  inst write flag (0 in practice, still forwarded).
- inst_sram_size  in  2  inst size.
- inst_sram_wstrb  in  4  inst byte strobe.
- inst_sram_addr  in  ADDR_W  inst address.
- inst_sram_wdata  in  DATA_W  inst write data.
- inst_sram_addr_ok  out  1  inst request accepted.
- inst_sram_data_ok  out  1  inst response valid.
- inst_sram_rdata  out  DATA_W  inst read data.
- data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata  in  1/1/2/4/ADDR_W/DATA_W  data requester, same meaning as inst.
- data_sram_addr_ok  out  1  data request accepted.
- data_sram_data_ok  out  1  data response valid.
- data_sram_rdata  out  DATA_W  data read data.
- mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/1/2/4/ADDR_W/DATA_W  to memory side.
- mem_addr_ok  in  1  memory accepted request.
- mem_data_ok  in  1  memory response; responses return in request order.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Requester rule: once req is high, the requester holds req and its payload stable until addr_ok.
- Grant, combinational:
  - lock_v=1: sel = lock_sel.
  - lock_v=0: sel = DATA if data_sram_req, else INST.
- mem_req = (sel requester's req) & ~fifo_full. mem_wr/size/wstrb/addr/wdata = sel requester's fields.
- addr_ok routing: mem_addr_ok & mem_req goes to the selected requester's addr_ok only; the other addr_ok = 0.
- Lock register:
  - Set (lock_v<=1, lock_sel<=sel) when mem_req & ~mem_addr_ok.
  - Cleared on handshake. A lower-priority request already on mem_req is never preempted.
- Handshake cycle (mem_req & mem_addr_ok): push sel into the ID FIFO.
- Response (mem_data_ok):
  - Pop FIFO head.
  - Head=INST: inst_sram_data_ok=1, inst_sram_rdata=mem_rdata.
  - Head=DATA: data_sram_data_ok=1, data_sram_rdata=mem_rdata.
  - Zero added latency; fully combinational pass-through.
  - rdata of the non-responding requester = 0.
- FIFO:
  - Count 0..OUTST_DEPTH; pointers wrap modulo OUTST_DEPTH.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Full: mem_req forced 0 (no same-cycle bypass, even if a pop occurs). Request resumes the next cycle.
  - mem_data_ok while empty: protocol error. No requester data_ok; pointers and count unchanged.
- Simultaneous requests, lock_v=0: data granted; inst waits (not locked) and is granted on the first cycle with lock_v=0 and no data_req.
- Reset (resetn=0 at posedge):
  - Clears count, pointers and lock_v.
  - Outputs after reset: all addr_ok/data_ok=0, rdata=0, mem_req=0 unless a requester's req is high.
  - Reset mid-operation drops all outstanding tags; later mem_data_ok follows the empty rule. The memory side is reset together.

Optional Feature:
- SRAM_ARB_RR_EN defined:
  - lock_v=0 with both reqs high: grant the requester not granted at the last handshake (last_sel reg, reset value INST, so data wins first).
  - last_sel updates on every handshake.
- Undefined: fixed data-over-inst priority; no last_sel register.

Decomposition:
- Package sram_arb_pkg:
  - MST_INST=1'b0, MST_DATA=1'b1.
  - Size constants SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - Default OUTST_DEPTH.
- Sub-module arb_id_fifo:
  - 1-bit-wide, OUTST_DEPTH-deep synchronous FIFO.
  - Ports: push, pop, din, dout, full, empty, clk, resetn.

Test Plan:
- Inst only: inst req addr 0x1c000000, mem_addr_ok same cycle, mem_data_ok 2 cycles later with 0x02800000 -> inst_sram_addr_ok=1 cycle 0; inst_sram_data_ok=1, rdata 0x02800000 cycle 2; data_sram_data_ok stays 0.
- Simultaneous reqs: inst 0x1c000004 and data 0x1c010000 load, mem_addr_ok=1 -> data granted first, inst next cycle. Responses 0xAAAA0000 then 0x5555FFFF reach data then inst, in order.
- Lock hold: inst req, mem_addr_ok held 0 for 3 cycles, data req rises in cycle 1 -> mem_addr stays 0x1c000008 until accept; data is granted the cycle after.
- Full FIFO, OUTST_DEPTH=4: 4 inst accepts, no data_ok -> mem_req=0 with inst req high. One mem_data_ok -> count 3; mem_req=1 the next cycle.
- Reset mid-flight: 2 outstanding, resetn=0 one cycle, then stray mem_data_ok -> no requester data_ok; count 0; new request accepted normally.
- SRAM_ARB_RR_EN: both reqs continuously high, mem_addr_ok always 1 -> grants alternate DATA, INST, DATA, INST. Without the macro -> DATA every cycle.

Source files
------------

// File: rtl/sram_req_arbiter_pkg.sv
// Shared types and constants for the two-requester SRAM-like port arbiter.
// Optional round-robin arbitration is enabled by the SRAM_ARB_RR_EN macro.
package sram_arb_pkg;

    typedef enum logic {
        MST_INST = 1'b0,
        MST_DATA = 1'b1
    } mst_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int OUTST_DEPTH_DEF = 4;

    // Pointer width for a power-of-two FIFO, never narrower than one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sram_req_arbiter_if.sv
// SRAM-like request/response bundle; master issues requests, slave answers them.
interface sram_req_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [3:0]        wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_req_arbiter_fifo.sv
// One-bit owner-tag FIFO tracking accepted-but-unanswered memory requests.
module arb_id_fifo
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = OUTST_DEPTH_DEF
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);
    localparam int PW = ptr_w(DEPTH);

    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [PW:0]    count_r;
    logic [DEPTH-1:0] tag_r;
    logic           do_push_s;
    logic           do_pop_s;

    assign full      = (count_r == (PW+1)'(DEPTH));
    assign empty     = (count_r == (PW+1)'(0));
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign dout      = tag_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= (PW+1)'(0);
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Tag storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push_s) tag_r[wr_ptr_r] <= din;
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// Arbitrates inst/data SRAM-like requesters onto one memory port and routes
// in-order responses back by owner tag. SRAM_ARB_RR_EN selects round-robin.
module sram_req_arbiter
    import sram_arb_pkg::*;
#(
    parameter int OUTST_DEPTH = OUTST_DEPTH_DEF,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    sram_req_arbiter_if.slave    inst_sram,
    sram_req_arbiter_if.slave    data_sram,
    sram_req_arbiter_if.master   mem
);
    mst_e              sel_s;
    mst_e              lock_sel_r;
    logic              lock_v_r;
    logic              sel_req_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              hs_s;
    logic              pop_s;
    logic              head_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;

`ifdef SRAM_ARB_RR_EN
    mst_e last_sel_r;

    // Grant select: lock wins, then the requester not served last on contention.
    always_comb begin
        sel_s = MST_INST;
        if (lock_v_r) begin
            sel_s = lock_sel_r;
        end else if (data_sram.req && inst_sram.req) begin
            sel_s = (last_sel_r == MST_DATA) ? MST_INST : MST_DATA;
        end else if (data_sram.req) begin
            sel_s = MST_DATA;
        end else begin
            sel_s = MST_INST;
        end
    end

    // Remember the owner of the most recent handshake.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_sel_r <= MST_INST;
        end else if (hs_s) begin
            last_sel_r <= sel_s;
        end
    end
`else
    // Grant select: lock wins, otherwise data has fixed priority over inst.
    always_comb begin
        sel_s = MST_INST;
        if (lock_v_r) begin
            sel_s = lock_sel_r;
        end else if (data_sram.req) begin
            sel_s = MST_DATA;
        end else begin
            sel_s = MST_INST;
        end
    end
`endif

    // Memory-side request mux; a full tag FIFO blocks issue with no bypass.
    always_comb begin
        if (sel_s == MST_DATA) begin
            sel_req_s   = data_sram.req;
            mem.wr      = data_sram.wr;
            mem.size    = data_sram.size;
            mem.wstrb   = data_sram.wstrb;
            sel_addr_s  = data_sram.addr;
            sel_wdata_s = data_sram.wdata;
        end else begin
            sel_req_s   = inst_sram.req;
            mem.wr      = inst_sram.wr;
            mem.size    = inst_sram.size;
            mem.wstrb   = inst_sram.wstrb;
            sel_addr_s  = inst_sram.addr;
            sel_wdata_s = inst_sram.wdata;
        end
        mem.req   = sel_req_s & ~fifo_full_s;
        mem.addr  = sel_addr_s;
        mem.wdata = sel_wdata_s;
    end

    assign hs_s  = mem.req & mem.addr_ok;
    assign pop_s = mem.data_ok & ~fifo_empty_s;

    // Accept and response routing; a stray response with no tag reaches nobody.
    always_comb begin
        inst_sram.addr_ok = hs_s & (sel_s == MST_INST);
        data_sram.addr_ok = hs_s & (sel_s == MST_DATA);
        inst_sram.data_ok = pop_s & (head_s == MST_INST);
        data_sram.data_ok = pop_s & (head_s == MST_DATA);
        inst_sram.rdata   = inst_sram.data_ok ? mem.rdata : {DATA_W{1'b0}};
        data_sram.rdata   = data_sram.data_ok ? mem.rdata : {DATA_W{1'b0}};
    end

    // Hold the grant on an issued-but-unaccepted request so it is never preempted.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_v_r   <= 1'b0;
            lock_sel_r <= MST_INST;
        end else if (hs_s) begin
            lock_v_r   <= 1'b0;
        end else if (mem.req) begin
            lock_v_r   <= 1'b1;
            lock_sel_r <= sel_s;
        end
    end

    arb_id_fifo #(
        .DEPTH (OUTST_DEPTH)
    ) u_id_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (hs_s),
        .pop    (pop_s),
        .din    (logic'(sel_s)),
        .dout   (head_s),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s)
    );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed self-checking bench for sram_req_arbiter with a response scoreboard.
module tb_sram_req_arbiter;
    import sram_arb_pkg::*;

    typedef struct {
        logic        who;
        logic [31:0] data;
    } sb_t;

    logic clk;
    logic resetn;
    int   checks;
    int   failures;
    logic rr_mode;
    sb_t  exp_q[$];

    sram_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_if ();
    sram_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_if ();
    sram_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

    sram_req_arbiter #(
        .OUTST_DEPTH (4),
        .ADDR_W      (32),
        .DATA_W      (32)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .inst_sram (inst_if),
        .data_sram (data_if),
        .mem       (mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag);
        sb_t e;
        chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_inst_data_ok"}, 32'(inst_if.data_ok), 32'(e.who == MST_INST));
            chk({tag, "_data_data_ok"}, 32'(data_if.data_ok), 32'(e.who == MST_DATA));
            chk({tag, "_inst_rdata"}, inst_if.rdata, (e.who == MST_INST) ? e.data : 32'h0);
            chk({tag, "_data_rdata"}, data_if.rdata, (e.who == MST_DATA) ? e.data : 32'h0);
        end
    endtask

    task automatic respond(input logic who, input logic [31:0] rd, input string tag);
        mem_if.data_ok = 1'b1;
        mem_if.rdata   = rd;
        exp_q.push_back('{who: who, data: rd});
        #1;
        sb_check(tag);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_if.req = 1'b0; inst_if.wr = 1'b0; inst_if.size = SZ_WORD;
        inst_if.wstrb = 4'h0; inst_if.addr = 32'h0; inst_if.wdata = 32'h0;
        data_if.req = 1'b0; data_if.wr = 1'b0; data_if.size = SZ_WORD;
        data_if.wstrb = 4'h0; data_if.addr = 32'h0; data_if.wdata = 32'h0;
        mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b0; mem_if.rdata = 32'h0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
`ifdef SRAM_ARB_RR_EN
        rr_mode = 1'b1;
`else
        rr_mode = 1'b0;
`endif
        resetn = 1'b0;
        idle();
        step();
        step();
        #1;
        chk("rst_mem_req", 32'(mem_if.req), 32'd0);
        chk("rst_inst_addr_ok", 32'(inst_if.addr_ok), 32'd0);
        chk("rst_data_data_ok", 32'(data_if.data_ok), 32'd0);
        chk("rst_inst_rdata", inst_if.rdata, 32'h0);
        resetn = 1'b1;

        // Inst only
        step();
        inst_if.req = 1'b1; inst_if.addr = 32'h1c000000; mem_if.addr_ok = 1'b1;
        #1;
        chk("t1_mem_req", 32'(mem_if.req), 32'd1);
        chk("t1_mem_addr", mem_if.addr, 32'h1c000000);
        chk("t1_mem_size", 32'(mem_if.size), 32'(SZ_WORD));
        chk("t1_inst_addr_ok", 32'(inst_if.addr_ok), 32'd1);
        chk("t1_data_addr_ok", 32'(data_if.addr_ok), 32'd0);
        step();
        idle();
        #1;
        chk("t1_c1_inst_data_ok", 32'(inst_if.data_ok), 32'd0);
        step();
        respond(MST_INST, 32'h02800000, "t1_resp");

        // Simultaneous requests: data first, inst the next cycle
        step();
        idle();
        inst_if.req = 1'b1; inst_if.addr = 32'h1c000004;
        data_if.req = 1'b1; data_if.addr = 32'h1c010000; data_if.wstrb = 4'hf;
        mem_if.addr_ok = 1'b1;
        #1;
        chk("t2_mem_addr0", mem_if.addr, 32'h1c010000);
        chk("t2_data_addr_ok", 32'(data_if.addr_ok), 32'd1);
        chk("t2_inst_addr_ok0", 32'(inst_if.addr_ok), 32'd0);
        chk("t2_mem_wstrb", 32'(mem_if.wstrb), 32'hf);
        step();
        data_if.req = 1'b0;
        #1;
        chk("t2_mem_addr1", mem_if.addr, 32'h1c000004);
        chk("t2_inst_addr_ok1", 32'(inst_if.addr_ok), 32'd1);
        step();
        idle();
        respond(MST_DATA, 32'hAAAA0000, "t2_resp0");
        step();
        respond(MST_INST, 32'h5555FFFF, "t2_resp1");

        // Lock hold
        step();
        idle();
        inst_if.req = 1'b1; inst_if.addr = 32'h1c000008;
        #1;
        chk("t3_c0_mem_addr", mem_if.addr, 32'h1c000008);
        step();
        data_if.req = 1'b1; data_if.addr = 32'h1c010004;
        #1;
        chk("t3_c1_mem_addr", mem_if.addr, 32'h1c000008);
        chk("t3_c1_data_addr_ok", 32'(data_if.addr_ok), 32'd0);
        step();
        #1;
        chk("t3_c2_mem_addr", mem_if.addr, 32'h1c000008);
        step();
        mem_if.addr_ok = 1'b1;
        #1;
        chk("t3_c3_mem_addr", mem_if.addr, 32'h1c000008);
        chk("t3_c3_inst_addr_ok", 32'(inst_if.addr_ok), 32'd1);
        chk("t3_c3_data_addr_ok", 32'(data_if.addr_ok), 32'd0);
        step();
        inst_if.req = 1'b0;
        #1;
        chk("t3_c4_mem_addr", mem_if.addr, 32'h1c010004);
        chk("t3_c4_data_addr_ok", 32'(data_if.addr_ok), 32'd1);
        step();
        idle();
        respond(MST_INST, 32'h11111111, "t3_resp0");
        step();
        respond(MST_DATA, 32'h22222222, "t3_resp1");

        // Full FIFO
        step();
        idle();
        inst_if.req = 1'b1; mem_if.addr_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            inst_if.addr = 32'h1c000010 + 32'(k * 4);
            #1;
            chk("t4_fill_addr_ok", 32'(inst_if.addr_ok), 32'd1);
            step();
        end
        inst_if.addr = 32'h1c000020;
        #1;
        chk("t4_full_mem_req", 32'(mem_if.req), 32'd0);
        chk("t4_full_addr_ok", 32'(inst_if.addr_ok), 32'd0);
        respond(MST_INST, 32'h33330000, "t4_pop");
        chk("t4_pop_no_bypass", 32'(mem_if.req), 32'd0);
        step();
        mem_if.data_ok = 1'b0;
        #1;
        chk("t4_resume_mem_req", 32'(mem_if.req), 32'd1);
        chk("t4_resume_addr_ok", 32'(inst_if.addr_ok), 32'd1);
        step();
        idle();
        for (int k = 0; k < 4; k++) begin
            respond(MST_INST, 32'h44440000 + 32'(k), "t4_drain");
            step();
        end

        // Reset mid-flight
        idle();
        inst_if.req = 1'b1; inst_if.addr = 32'h1c000100; mem_if.addr_ok = 1'b1;
        step();
        inst_if.addr = 32'h1c000104;
        step();
        idle();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        mem_if.data_ok = 1'b1; mem_if.rdata = 32'hDEADBEEF;
        #1;
        chk("t5_stray_inst_data_ok", 32'(inst_if.data_ok), 32'd0);
        chk("t5_stray_data_data_ok", 32'(data_if.data_ok), 32'd0);
        chk("t5_stray_inst_rdata", inst_if.rdata, 32'h0);
        step();
        idle();
        data_if.req = 1'b1; data_if.wr = 1'b1; data_if.size = SZ_HALF;
        data_if.wstrb = 4'b0011; data_if.addr = 32'h1c020000; data_if.wdata = 32'h12345678;
        mem_if.addr_ok = 1'b1;
        #1;
        chk("t5_new_addr_ok", 32'(data_if.addr_ok), 32'd1);
        chk("t5_mem_wr", 32'(mem_if.wr), 32'd1);
        chk("t5_mem_size", 32'(mem_if.size), 32'(SZ_HALF));
        chk("t5_mem_wstrb", 32'(mem_if.wstrb), 32'h3);
        chk("t5_mem_wdata", mem_if.wdata, 32'h12345678);
        step();
        idle();
        respond(MST_DATA, 32'hCAFE0001, "t5_resp");

        // Arbitration pattern under continuous contention
        step();
        idle();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        inst_if.req = 1'b1; inst_if.addr = 32'h1c000200;
        data_if.req = 1'b1; data_if.addr = 32'h1c030000;
        mem_if.addr_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic exp_data;
            exp_data = rr_mode ? ((k % 2) == 0) : 1'b1;
            #1;
            chk("t6_data_addr_ok", 32'(data_if.addr_ok), 32'(exp_data));
            chk("t6_inst_addr_ok", 32'(inst_if.addr_ok), 32'(!exp_data));
            chk("t6_mem_addr", mem_if.addr, exp_data ? 32'h1c030000 : 32'h1c000200);
            step();
        end
        idle();
        resetn = 1'b0;
        step();
        resetn = 1'b1;

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
